// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants for the VGA raster path.
// Holds the default 640x480@60 timing, the sync polarities and the counter width.
// The pixel/colour generator imports the same package so that its visible-area size
// always matches this timing generator.
// Also provides a helper that sums the four segments of one scan axis.

package vga_timing_gen_pkg;

   // Horizontal timing, in pixels
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;

   // Vertical timing, in lines
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Sync asserted levels (0 = active-low, as in the classic 640x480 mode)
   localparam bit DEF_H_SYNC_POL = 1'b0;
   localparam bit DEF_V_SYNC_POL = 1'b0;

   // Counter width; must cover the larger of the two axis totals
   localparam int DEF_CNT_W = 10;

   // Length of one full scan axis: visible area plus both porches plus sync.
   function automatic int axis_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle, from the timing generator to the pixel generator and the connector.
// The master modport is the timing generator; the slave modport is any consumer.
//   h_count     current pixel column
//   v_count     current line
//   hsync       horizontal sync (asserted level set by the generator's polarity)
//   vsync       vertical sync
//   de          display enable: the current position is inside the visible area
//   line_start  one-clock pulse when the column wraps to 0
//   frame_start one-clock pulse when the position wraps to (0,0)

interface vga_timing_gen_if
   import vga_timing_gen_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);

   logic [CNT_W-1:0] h_count;
   logic [CNT_W-1:0] v_count;
   logic             hsync;
   logic             vsync;
   logic             de;
   logic             line_start;
   logic             frame_start;

   modport master (
      output h_count, v_count, hsync, vsync, de, line_start, frame_start
   );

   modport slave (
      input  h_count, v_count, hsync, vsync, de, line_start, frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis of the raster: a position counter running 0..TOTAL-1 with decoded
// sync and visible-area flags and a wrap pulse.
// Ports:
//   clk     system clock
//   reset   synchronous, active-high; returns the axis to position 0
//   ce      advance enable; the position moves by one only when high
//   count   current position
//   sync    sync output at its asserted level (POL) inside the sync window
//   active  position is inside the visible area
//   wrap    one-clock pulse in the cycle the position has just wrapped to 0
// sync and active are decoded from the next position and registered together with it,
// so all outputs always describe the same position.

module vga_axis_counter #(
   parameter int TOTAL  = 800,
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter bit POL    = 1'b0,
   parameter int CNT_W  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   output logic [CNT_W-1:0] count,
   output logic             sync,
   output logic             active,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

   // Window limits carry one extra bit so a sync window ending exactly at
   // 2**CNT_W (zero back porch on a full-width axis) is still representable.
   localparam logic [CNT_W:0] ACTIVE_END = (CNT_W + 1)'(ACTIVE);
   localparam logic [CNT_W:0] SYNC_START = (CNT_W + 1)'(ACTIVE + FP);
   localparam logic [CNT_W:0] SYNC_END   = (CNT_W + 1)'(ACTIVE + FP + SYNC);

   logic             at_last;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W:0]   count_next_ext;
   logic             sync_next;
   logic             active_next;

   // Next position and the flags that will belong to it. The counter wraps at
   // TOTAL-1, never at the natural 2**CNT_W rollover.
   always_comb begin
      at_last        = (count == LAST);
      count_next     = at_last ? '0 : count + CNT_W'(1);
      count_next_ext = {1'b0, count_next};
      sync_next      = ((count_next_ext >= SYNC_START) && (count_next_ext < SYNC_END)) ? POL : ~POL;
      active_next    = (count_next_ext < ACTIVE_END);
   end

   // Position, sync and active hold while ce is low; the wrap pulse is cleared on
   // every cycle that does not itself wrap so it can never stretch past one clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         sync   <= ~POL;
         active <= (ACTIVE > 0);
         wrap   <= 1'b0;
      end else if (ce) begin
         count  <= count_next;
         sync   <= sync_next;
         active <= active_next;
         wrap   <= at_last;
      end else begin
         wrap   <= 1'b0;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Runs from the system clock and advances one pixel per cycle that ce is high.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; restarts the raster at (0,0)
//   ce     pixel clock enable
//   vga    timing bundle (master): h_count, v_count, hsync, vsync, de,
//          line_start, frame_start
// The horizontal axis steps on every enabled pixel; the vertical axis steps only on
// the enabled pixel that ends a line. Every output is a register or an AND of
// registers, so the whole bundle is aligned to one raster position.

module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter bit H_SYNC_POL = DEF_H_SYNC_POL,
   parameter bit V_SYNC_POL = DEF_V_SYNC_POL,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);

   logic [CNT_W-1:0] h_count;
   logic [CNT_W-1:0] v_count;
   logic             h_sync;
   logic             h_active;
   logic             h_wrap;
   logic             v_sync;
   logic             v_active;
   logic             v_wrap;
   logic             v_ce;

   // The line advances on the same enabled pixel that takes the column back to 0.
   assign v_ce = ce & (h_count == H_LAST);

   vga_axis_counter #(
      .TOTAL  (H_TOTAL),
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .POL    (H_SYNC_POL),
      .CNT_W  (CNT_W)
   ) h_axis (
      .clk    (clk),
      .reset  (reset),
      .ce     (ce),
      .count  (h_count),
      .sync   (h_sync),
      .active (h_active),
      .wrap   (h_wrap)
   );

   vga_axis_counter #(
      .TOTAL  (V_TOTAL),
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .POL    (V_SYNC_POL),
      .CNT_W  (CNT_W)
   ) v_axis (
      .clk    (clk),
      .reset  (reset),
      .ce     (v_ce),
      .count  (v_count),
      .sync   (v_sync),
      .active (v_active),
      .wrap   (v_wrap)
   );

   // The vertical wrap pulse is only ever raised on a line wrap, so ANDing it with
   // the line pulse marks exactly the return to (0,0).
   assign vga.h_count     = h_count;
   assign vga.v_count     = v_count;
   assign vga.hsync       = h_sync;
   assign vga.vsync       = v_sync;
   assign vga.de          = h_active & v_active;
   assign vga.line_start  = h_wrap;
   assign vga.frame_start = h_wrap & v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen.
// Three generators share clk/reset/ce: the default 640x480 timing, a mid-size timing
// whose frames are short enough to wrap many times, and the tiny 8x4 timing with
// active-high hsync. The driver pushes the expected bundle for every clock into one
// queue per generator; the monitor pops and compares one cycle later.
// The reference tracks the raster as a single pixel index within the frame and
// derives column, line, syncs and pulses from it with plain arithmetic.

`timescale 1ns/1ps

module tb_vga_timing_gen;

   typedef struct {
      int ha, hf, hs, hb;
      int va, vf, vs, vb;
      bit hpol, vpol;
   } cfg_t;

   typedef struct packed {
      logic [15:0] h;
      logic [15:0] v;
      logic        hs;
      logic        vs;
      logic        de;
      logic        ls;
      logic        fs;
   } out_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ce = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.CNT_W(10)) vga_big ();
   vga_timing_gen_if #(.CNT_W(6))  vga_mid ();
   vga_timing_gen_if #(.CNT_W(4))  vga_small ();

   vga_timing_gen dut_big (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .vga   (vga_big)
   );

   vga_timing_gen #(
      .H_ACTIVE (20), .H_FP (2), .H_SYNC (3), .H_BP (5),
      .V_ACTIVE (10), .V_FP (2), .V_SYNC (2), .V_BP (3),
      .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b1), .CNT_W (6)
   ) dut_mid (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .vga   (vga_mid)
   );

   vga_timing_gen #(
      .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (0),
      .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b0), .CNT_W (4)
   ) dut_small (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .vga   (vga_small)
   );

   cfg_t cfg [3];
   int   pos [3];
   bit   ls  [3];
   bit   fs  [3];

   out_t q_big[$];
   out_t q_mid[$];
   out_t q_small[$];

   int n_compared = 0;
   int n_mismatch = 0;
   int cycle = 0;

   // Expected bundle for a configuration at a pixel index within the frame.
   function automatic out_t model_out(input cfg_t c, input int p, input bit l, input bit f);
      out_t e;
      int ht, h, v;
      ht     = c.ha + c.hf + c.hs + c.hb;
      h      = p % ht;
      v      = p / ht;
      e.h    = 16'(h);
      e.v    = 16'(v);
      e.hs   = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hpol : !c.hpol;
      e.vs   = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vpol : !c.vpol;
      e.de   = (h < c.ha) && (v < c.va);
      e.ls   = l;
      e.fs   = f;
      return e;
   endfunction

   // Advance one reference raster by the clock edge that will sample rst/enable.
   task automatic model_step(input int i, input bit rst, input bit en);
      int ht, vt;
      ht = cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb;
      vt = cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb;
      if (rst) begin
         pos[i] = 0;
         ls[i]  = 1'b0;
         fs[i]  = 1'b0;
      end else if (en) begin
         pos[i] = (pos[i] + 1) % (ht * vt);
         ls[i]  = (pos[i] % ht) == 0;
         fs[i]  = (pos[i] == 0);
      end else begin
         ls[i]  = 1'b0;
         fs[i]  = 1'b0;
      end
   endtask

   // Drive one clock of stimulus and queue the response each generator must show after it.
   task automatic applyStimulus(input bit rst, input bit en);
      @(negedge clk);
      reset = rst;
      ce    = en;
      for (int i = 0; i < 3; i++) model_step(i, rst, en);
      q_big.push_back(model_out(cfg[0], pos[0], ls[0], fs[0]));
      q_mid.push_back(model_out(cfg[1], pos[1], ls[1], fs[1]));
      q_small.push_back(model_out(cfg[2], pos[2], ls[2], fs[2]));
   endtask

   task automatic checkOutput(input string name, input out_t act, input out_t exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatch++;
         $display("[TB] FAIL %s cycle %0d: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                  name, cycle, act.h, act.v, act.hs, act.vs, act.de, act.ls, act.fs,
                  exp.h, exp.v, exp.hs, exp.vs, exp.de, exp.ls, exp.fs);
      end
   endtask

   // Monitor: shortly after each rising edge, compare every generator against the
   // oldest queued expectation.
   initial begin
      out_t act;
      out_t exp;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (q_big.size() > 0) begin
            exp = q_big.pop_front();
            act = '{16'(vga_big.h_count), 16'(vga_big.v_count), vga_big.hsync, vga_big.vsync,
                    vga_big.de, vga_big.line_start, vga_big.frame_start};
            checkOutput("big", act, exp);
         end
         if (q_mid.size() > 0) begin
            exp = q_mid.pop_front();
            act = '{16'(vga_mid.h_count), 16'(vga_mid.v_count), vga_mid.hsync, vga_mid.vsync,
                    vga_mid.de, vga_mid.line_start, vga_mid.frame_start};
            checkOutput("mid", act, exp);
         end
         if (q_small.size() > 0) begin
            exp = q_small.pop_front();
            act = '{16'(vga_small.h_count), 16'(vga_small.v_count), vga_small.hsync, vga_small.vsync,
                    vga_small.de, vga_small.line_start, vga_small.frame_start};
            checkOutput("small", act, exp);
         end
      end
   end

   initial begin
      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
      cfg[1] = '{20, 2, 3, 5, 10, 2, 2, 3, 1'b0, 1'b1};
      cfg[2] = '{4, 1, 2, 1, 2, 1, 1, 0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         pos[i] = 0;
         ls[i]  = 1'b0;
         fs[i]  = 1'b0;
      end

      $display("[TB] reset held three clocks with ce high");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);

      $display("[TB] continuous ce across several lines and small-frame wraps");
      for (int i = 0; i < 2000; i++) applyStimulus(1'b0, 1'b1);

      $display("[TB] ce pattern 1-0-0-1 and a mid-raster reset");
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 900; i++) applyStimulus(1'b0, 1'b1);

      $display("[TB] randomized ce with occasional resets");
      for (int i = 0; i < 55000; i++) begin
         applyStimulus($urandom_range(0, 2999) == 0, $urandom_range(0, 9) < 7);
      end

      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      @(posedge clk);
      #3;

      n_compared++;
      if (q_big.size() != 0 || q_mid.size() != 0 || q_small.size() != 0) begin
         n_mismatch++;
         $display("[TB] FAIL drain: got %0d/%0d/%0d entries left, expected 0/0/0",
                  q_big.size(), q_mid.size(), q_small.size());
      end
      n_compared++;
      if (n_compared < 100) begin
         n_mismatch++;
         $display("[TB] FAIL activity: got %0d comparisons, expected at least 100", n_compared);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
